// File: rtl/multi_way_traffic_ctrl.sv
// Round-robin traffic light controller for NUM_WAYS approaches: GREEN -> YELLOW -> ALLRED -> GREEN.
// Optional emergency preemption is compiled in when TRAFFIC_PREEMPT_EN is defined.
module multi_way_traffic_ctrl #(
  parameter int NUM_WAYS      = 4,
  parameter int MAX_WAIT      = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int DEFAULT_WAY   = 0,
  localparam int WAY_W        = ($clog2(NUM_WAYS) > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WAYS-1:0] waiting,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                preempt_req,
  input  logic [WAY_W-1:0]    preempt_way,
`endif
  output logic [NUM_WAYS-1:0] green,
  output logic [NUM_WAYS-1:0] yellow,
  output logic [NUM_WAYS-1:0] red,
  output logic [WAY_W-1:0]    active_way,
  output logic [1:0]          state_out
);

  localparam logic [1:0] ST_GREEN  = 2'b00;
  localparam logic [1:0] ST_YELLOW = 2'b01;
  localparam logic [1:0] ST_ALLRED = 2'b10;

  localparam logic [7:0]       GREEN_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [7:0]       YELLOW_LAST = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0]       ALLRED_LAST = 8'(ALLRED_CYCLES - 1);
  localparam logic [WAY_W-1:0] DEF_WAY     = WAY_W'(DEFAULT_WAY);
  localparam logic [WAY_W:0]   NUM_WAYS_L  = (WAY_W + 1)'(NUM_WAYS);

  logic [1:0]          state_q, state_d;
  logic [WAY_W-1:0]    active_q, active_d;
  logic [WAY_W-1:0]    next_q, next_d;
  logic [7:0]          timer_q, timer_d;

  logic [NUM_WAYS-1:0] activeMask;
  logic                otherWaiting;
  logic [WAY_W-1:0]    rrPick;
  logic                greenExit;
  logic [WAY_W-1:0]    greenTarget;

  assign activeMask   = {{(NUM_WAYS-1){1'b0}}, 1'b1} << active_q;
  assign otherWaiting = |(waiting & ~activeMask);

  // Scan from the farthest candidate down so the nearest waiting way after active_q wins.
  always_comb begin
    logic [WAY_W:0] sum;
    rrPick = active_q;
    sum    = '0;
    for (int k = NUM_WAYS - 1; k >= 1; k--) begin
      sum = {1'b0, active_q} + (WAY_W + 1)'(k);
      if (sum >= NUM_WAYS_L) begin
        sum = sum - NUM_WAYS_L;
      end
      if (waiting[sum[WAY_W-1:0]]) begin
        rrPick = sum[WAY_W-1:0];
      end
    end
  end

  always_comb begin
    greenTarget = rrPick;
    greenExit   = (timer_q >= GREEN_LAST) && otherWaiting;
`ifdef TRAFFIC_PREEMPT_EN
    // A valid preempt request overrides the normal exit; naming the current way pins green.
    if (preempt_req && ({1'b0, preempt_way} < NUM_WAYS_L)) begin
      greenExit   = (preempt_way != active_q);
      greenTarget = preempt_way;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    next_d   = next_q;
    timer_d  = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    case (state_q)
      ST_GREEN: begin
        if (greenExit) begin
          state_d = ST_YELLOW;
          next_d  = greenTarget;
          timer_d = 8'd0;
        end
      end
      ST_YELLOW: begin
        if (timer_q >= YELLOW_LAST) begin
          state_d = ST_ALLRED;
          timer_d = 8'd0;
        end
      end
      ST_ALLRED: begin
        if (timer_q >= ALLRED_LAST) begin
          state_d  = ST_GREEN;
          active_d = next_q;
          timer_d  = 8'd0;
        end
      end
      default: begin
        state_d  = ST_GREEN;
        active_d = DEF_WAY;
        next_d   = DEF_WAY;
        timer_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_GREEN;
      active_q <= DEF_WAY;
      next_q   <= DEF_WAY;
      timer_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      next_q   <= next_d;
      timer_q  <= timer_d;
    end
  end

  // Lamps are decoded purely from registered state so waiting never reaches an output.
  always_comb begin
    green  = '0;
    yellow = '0;
    if (state_q == ST_GREEN) begin
      green = activeMask;
    end else if (state_q == ST_YELLOW) begin
      yellow = activeMask;
    end
    red = ~(green | yellow);
  end

  assign active_way = active_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_multi_way_traffic_ctrl.sv
// Directed self-checking bench for multi_way_traffic_ctrl with default parameters.
// Preemption steps are included when TRAFFIC_PREEMPT_EN is defined.
module tb_multi_way_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] waiting = 4'b0000;
  logic [3:0] green, yellow, red;
  logic [1:0] active_way;
  logic [1:0] state_out;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt_req = 1'b0;
  logic [1:0] preempt_way = 2'd0;
`endif

  int compared   = 0;
  int mismatched = 0;

  multi_way_traffic_ctrl #(
    .NUM_WAYS(4), .MAX_WAIT(4), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1), .DEFAULT_WAY(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .waiting    (waiting),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt_req(preempt_req),
    .preempt_way(preempt_way),
`endif
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .active_way (active_way),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving the bench 1 time unit past the last edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkLamps(input string tag, input logic [3:0] g, input logic [3:0] y,
                            input logic [3:0] r);
    checkOutput(tag, {4'h0, green, yellow, red}, {4'h0, g, y, r});
  endtask

  initial begin
    logic [3:0] eg, ey, er;
    logic [1:0] es;

    // Power-on reset.
    rst = 1'b0;
    waiting = 4'b0000;
    applyStimulus(2);
    rst = 1'b1;
    checkLamps("reset_lamps", 4'b0001, 4'b0000, 4'b1110);
    checkOutput("reset_state", {14'd0, state_out}, 16'd0);
    checkOutput("reset_active", {14'd0, active_way}, 16'd0);

    // Nobody else waiting: green holds, own request ignored.
    for (int i = 0; i < 20; i++) begin
      waiting = (i < 10) ? 4'b0000 : 4'b0001;
      checkLamps("idle_hold", 4'b0001, 4'b0000, 4'b1110);
      applyStimulus(1);
    end

    // Long green already past minimum: a new request leaves on the next edge.
    waiting = 4'b0010;
    applyStimulus(1);
    checkLamps("late_req_yellow", 4'b0000, 4'b0001, 4'b1110);
    checkOutput("late_req_state", {14'd0, state_out}, 16'd1);

    // Reset in yellow, then the basic single-request sequence.
    rst = 1'b0;
    applyStimulus(1);
    checkLamps("reset_in_yellow", 4'b0001, 4'b0000, 4'b1110);
    applyStimulus(1);
    rst = 1'b1;
    waiting = 4'b0100;
    for (int c = 0; c <= 7; c++) begin
      if (c < 4) begin
        eg = 4'b0001; ey = 4'b0000; er = 4'b1110; es = 2'b00;
      end else if (c < 6) begin
        eg = 4'b0000; ey = 4'b0001; er = 4'b1110; es = 2'b01;
      end else if (c == 6) begin
        eg = 4'b0000; ey = 4'b0000; er = 4'b1111; es = 2'b10;
      end else begin
        eg = 4'b0100; ey = 4'b0000; er = 4'b1011; es = 2'b00;
      end
      checkLamps($sformatf("seq_lamps_c%0d", c), eg, ey, er);
      checkOutput($sformatf("seq_state_c%0d", c), {14'd0, state_out}, {14'd0, es});
      if (c < 7) applyStimulus(1);
    end
    checkOutput("seq_active_way2", {14'd0, active_way}, 16'd2);

    // Rotate to way 1 (wrapping past way 3 and way 0).
    waiting = 4'b0010;
    applyStimulus(7);
    checkLamps("rot_to_way1", 4'b0010, 4'b0000, 4'b1101);
    checkOutput("rot_active_way1", {14'd0, active_way}, 16'd1);

    // From way 1 with ways 0 and 3 waiting: way 3 first, then way 0.
    waiting = 4'b1001;
    applyStimulus(4);
    checkLamps("w1_yellow", 4'b0000, 4'b0010, 4'b1101);
    applyStimulus(2);
    checkLamps("w1_allred", 4'b0000, 4'b0000, 4'b1111);
    applyStimulus(1);
    checkLamps("rr_way3", 4'b1000, 4'b0000, 4'b0111);
    checkOutput("rr_active_way3", {14'd0, active_way}, 16'd3);
    applyStimulus(4);
    checkLamps("w3_yellow", 4'b0000, 4'b1000, 4'b0111);
    // Dropping the request after the exit must not change the latched way.
    waiting = 4'b0000;
    applyStimulus(3);
    checkLamps("rr_way0_latched", 4'b0001, 4'b0000, 4'b1110);
    checkOutput("rr_active_way0", {14'd0, active_way}, 16'd0);

    // Reset asserted in the second yellow cycle.
    waiting = 4'b0010;
    applyStimulus(5);
    checkLamps("second_yellow", 4'b0000, 4'b0001, 4'b1110);
    rst = 1'b0;
    applyStimulus(1);
    checkLamps("reset_2nd_yellow", 4'b0001, 4'b0000, 4'b1110);
    checkOutput("reset_2nd_yellow_st", {14'd0, state_out}, 16'd0);
    rst = 1'b1;
    waiting = 4'b0000;

    // Two-cycle reset while way 2 holds green.
    waiting = 4'b0100;
    applyStimulus(7);
    checkLamps("pre_reset_way2", 4'b0100, 4'b0000, 4'b1011);
    rst = 1'b0;
    applyStimulus(1);
    checkLamps("midrun_reset_1", 4'b0001, 4'b0000, 4'b1110);
    applyStimulus(1);
    rst = 1'b1;
    waiting = 4'b0000;
    checkLamps("midrun_reset_2", 4'b0001, 4'b0000, 4'b1110);
    checkOutput("midrun_reset_state", {14'd0, state_out}, 16'd0);
    checkOutput("midrun_reset_active", {14'd0, active_way}, 16'd0);

`ifdef TRAFFIC_PREEMPT_EN
    // Preempt to way 3 at timer 1, held high through yellow and all-red.
    applyStimulus(1);
    preempt_req = 1'b1;
    preempt_way = 2'd3;
    applyStimulus(1);
    checkLamps("pre_yellow_1", 4'b0000, 4'b0001, 4'b1110);
    applyStimulus(1);
    checkLamps("pre_yellow_2", 4'b0000, 4'b0001, 4'b1110);
    applyStimulus(1);
    checkLamps("pre_allred", 4'b0000, 4'b0000, 4'b1111);
    applyStimulus(1);
    checkLamps("pre_green_way3", 4'b1000, 4'b0000, 4'b0111);
    // Preempting the current way blocks the normal exit.
    waiting = 4'b0001;
    applyStimulus(6);
    checkLamps("pre_hold_way3", 4'b1000, 4'b0000, 4'b0111);
    preempt_req = 1'b0;
    applyStimulus(1);
    checkLamps("pre_release_exit", 4'b0000, 4'b1000, 4'b0111);
    waiting = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
